addsub_accumulator: RTL and testbench

Sequencing stage directly upstream of the `AddSub` datapath. It accepts operations through a valid/ready handshake and holds the running accumulator. It drives `AddSub`'s A/B/Ctrl inputs from registered operands, then captures S/Co back into the accumulator and status flags. It turns the purely combinational adder into a multi-cycle accumulate unit for the lab's board-level top.

---
 rtl/addsub_accumulator.sv | 195 +++++++++++++++++++
 tb/tb_addsub_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accumulator.sv
// ---------------------------------------------------------------------------
// addsub_accumulator
//
// Sequencing stage in front of the combinational AddSub datapath. A request
// (op + operand) is taken through a valid/ready handshake. The registered
// accumulator and operand are driven to AddSub for one full cycle. The sum
// or difference and carry/borrow are then written back into the accumulator
// and status flags. One operation completes every three cycles:
// IDLE -> EXEC -> DONE.
//
// Build option:
//   ACC_SATURATE_EN  when defined, an ADD/SUB with signed overflow clamps
//                    the accumulator to the most positive or most negative
//                    value instead of wrapping. When undefined, the
//                    accumulator wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH      operand/accumulator width (>= 2); must match AddSub
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present
//   in_ready   request can be accepted (high only in IDLE)
//   op         00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   operand    B operand, or load value for LOAD
//   add_a      to AddSub.A    (registered accumulator)
//   add_b      to AddSub.B    (registered operand)
//   add_ctrl   to AddSub.Ctrl (1 = subtract)
//   add_s      from AddSub.S
//   add_co     from AddSub.Co (carry on add, borrow on sub)
//   acc        accumulator value
//   carry      last ADD carry-out or SUB borrow
//   overflow   last ADD/SUB signed overflow
//   zero       accumulator is zero
//   out_valid  one-cycle pulse when acc/flags were updated
// ---------------------------------------------------------------------------
module addsub_accumulator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_ctrl,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_co,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] operand_q;

   logic             sum_overflow;
   logic [WIDTH-1:0] arith_result;
   logic [WIDTH-1:0] next_acc;
   logic             next_carry;
   logic             next_overflow;

   // The handshake is taken only in IDLE, so ready is a plain state decode.
   assign in_ready = (state == IDLE);

   // Signed overflow is judged on the operands actually presented to AddSub.
   // A subtract overflows when the operand signs differ and the result sign
   // departs from A. An add overflows when the signs agree and the result
   // sign departs from them.
   always_comb begin
      sum_overflow = 1'b0;
      if (op_q == OP_ADD) begin
         sum_overflow = (add_a[MSB] == add_b[MSB]) && (add_s[MSB] != add_a[MSB]);
      end else if (op_q == OP_SUB) begin
         sum_overflow = (add_a[MSB] != add_b[MSB]) && (add_s[MSB] != add_a[MSB]);
      end
   end

`ifdef ACC_SATURATE_EN
   // On overflow, a wrapped result with its MSB set came from a positive
   // overflow, so it clamps to the largest positive value. Otherwise it
   // clamps to the most negative value.
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   always_comb begin
      arith_result = add_s;
      if (sum_overflow) begin
         arith_result = add_s[MSB] ? SAT_MAX : SAT_MIN;
      end
   end
`else
   // Plain two's-complement wrap: the adder output is taken as-is.
   always_comb begin
      arith_result = add_s;
   end
`endif

   // Write-back selection for the end of EXEC. LOAD and CLEAR bypass the
   // adder and clear both flags. ADD and SUB take the adder result. They
   // also take its carry/borrow, which is reported even when overflow is set.
   always_comb begin
      next_acc      = '0;
      next_carry    = 1'b0;
      next_overflow = 1'b0;
      case (op_q)
         OP_LOAD: begin
            next_acc = operand_q;
         end
         OP_ADD, OP_SUB: begin
            next_acc      = arith_result;
            next_carry    = add_co;
            next_overflow = sum_overflow;
         end
         OP_CLEAR: begin
            next_acc = '0;
         end
         default: begin
            next_acc = '0;
         end
      endcase
   end

   // Sequencer. The AddSub inputs are loaded at the accept edge, so the
   // adder has the whole EXEC cycle to settle. They return to zero at the
   // write-back edge, which keeps add_ctrl high only during EXEC. Reset can
   // abort an operation at any point, which also drops out_valid at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= OP_LOAD;
         operand_q <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_ctrl  <= 1'b0;
         acc       <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q      <= op;
                  operand_q <= operand;
                  add_a     <= acc;
                  add_b     <= operand;
                  add_ctrl  <= (op == OP_SUB);
                  state     <= EXEC;
               end
            end
            EXEC: begin
               acc       <= next_acc;
               carry     <= next_carry;
               overflow  <= next_overflow;
               zero      <= (next_acc == '0);
               out_valid <= 1'b1;
               add_a     <= '0;
               add_b     <= '0;
               add_ctrl  <= 1'b0;
               state     <= DONE;
            end
            DONE: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_accumulator.sv
// ---------------------------------------------------------------------------
// tb_addsub_accumulator
//
// Testbench for addsub_accumulator. A behavioural AddSub closes the loop
// from add_a/add_b/add_ctrl to add_s/add_co. Directed operations are issued
// by applyStimulus. Each one pushes its hand-computed result into a
// scoreboard queue. A monitor pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_addsub_accumulator;

   localparam int WIDTH = 8;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_ctrl;
   logic [WIDTH-1:0] add_s;
   logic             add_co;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             out_valid;
   logic [WIDTH:0]   sum_wide;

   typedef struct {
      logic [7:0] acc;
      logic       carry;
      logic       overflow;
      logic       zero;
      int         due_neg;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   int         vec_count  = 0;
   int         miss_count = 0;
   int         neg_count  = 0;
   int         last_accept = 0;
   logic [7:0] prev_acc = 8'h00;

   // Free-running clock.
   always #5 clk = ~clk;

   // Behavioural AddSub: the borrow on subtract is 1 when A < B unsigned.
   assign sum_wide = {1'b0, add_a} + {1'b0, add_b};
   assign add_s    = add_ctrl ? (add_a - add_b) : sum_wide[WIDTH-1:0];
   assign add_co   = add_ctrl ? (add_a < add_b) : sum_wide[WIDTH];

   addsub_accumulator #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand   (operand),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_ctrl  (add_ctrl),
      .add_s     (add_s),
      .add_co    (add_co),
      .acc       (acc),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .out_valid (out_valid)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: counts falling edges and checks each result pulse against the
   // oldest scoreboard entry, including the cycle on which it arrived.
   always @(negedge clk) begin
      neg_count++;
      if (!rst && out_valid) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            checkOutput("acc",      32'(acc),      32'(mon_e.acc));
            checkOutput("carry",    32'(carry),    32'(mon_e.carry));
            checkOutput("overflow", 32'(overflow), 32'(mon_e.overflow));
            checkOutput("zero",     32'(zero),     32'(mon_e.zero));
            checkOutput("out_valid_latency", 32'(neg_count), 32'(mon_e.due_neg));
         end
      end
   end

   // Issue one request, wait (bounded) for acceptance, and queue the
   // expected result. During EXEC, check what is driven to AddSub.
   task automatic applyStimulus(input logic [1:0] o, input logic [7:0] v,
                                input logic [7:0] e_acc, input logic e_c,
                                input logic e_o, input logic e_z,
                                input bit hold_valid);
      int   waits = 0;
      exp_t e;
      @(negedge clk);
      while (!in_ready && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      op       = o;
      operand  = v;
      in_valid = 1'b1;
      @(posedge clk);
      last_accept = neg_count;
      e.acc      = e_acc;
      e.carry    = e_c;
      e.overflow = e_o;
      e.zero     = e_z;
      e.due_neg  = neg_count + 2;
      sbq.push_back(e);
      @(negedge clk);
      checkOutput("exec_in_ready", 32'(in_ready), 32'd0);
      checkOutput("exec_add_ctrl", 32'(add_ctrl), 32'(o == OP_SUB));
      checkOutput("exec_add_a",    32'(add_a),    32'(prev_acc));
      checkOutput("exec_add_b",    32'(add_b),    32'(v));
      prev_acc = e_acc;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   initial begin
      int prev_accept;
      int waits;
      rst      = 1'b1;
      in_valid = 1'b0;
      op       = OP_LOAD;
      operand  = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("rst_acc",       32'(acc),       32'h00);
      checkOutput("rst_zero",      32'(zero),      32'd1);
      checkOutput("rst_carry",     32'(carry),     32'd0);
      checkOutput("rst_overflow",  32'(overflow),  32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_add_a",     32'(add_a),     32'h00);
      checkOutput("rst_add_ctrl",  32'(add_ctrl),  32'd0);
      rst = 1'b0;

      // Basic load and add.
      applyStimulus(OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_ADD,  8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);

      // Positive signed overflow on add.
      applyStimulus(OP_LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
      applyStimulus(OP_ADD,  8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
`else
      applyStimulus(OP_ADD,  8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

      // Subtract with borrow, no signed overflow.
      applyStimulus(OP_LOAD, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_SUB,  8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);

      // Unsigned wrap to zero with carry, then CLEAR ignoring its operand.
      applyStimulus(OP_LOAD,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_ADD,   8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(OP_CLEAR, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Negative signed overflow on subtract.
      applyStimulus(OP_LOAD, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
      applyStimulus(OP_SUB,  8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
`else
      applyStimulus(OP_SUB,  8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

      // Back-to-back adds with in_valid held high: accepts every 3 cycles.
      applyStimulus(OP_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_ADD,  8'h01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
      prev_accept = last_accept;
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(OP_ADD, 8'h01, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1);
         checkOutput("held_accept_spacing", 32'(last_accept - prev_accept), 32'd3);
         prev_accept = last_accept;
      end
      in_valid = 1'b0;

      // Reset in the middle of EXEC aborts the operation with no write-back.
      applyStimulus(OP_LOAD, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      op       = OP_ADD;
      operand  = 8'h10;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_exec_add_a", 32'(add_a), 32'h20);
      rst = 1'b1;
      #1;
      checkOutput("abort_in_ready",  32'(in_ready),  32'd1);
      checkOutput("abort_acc",       32'(acc),       32'h00);
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prev_acc = 8'h00;
      repeat (4) @(negedge clk);
      checkOutput("post_abort_in_ready", 32'(in_ready), 32'd1);
      checkOutput("post_abort_acc",      32'(acc),      32'h00);
      checkOutput("post_abort_zero",     32'(zero),     32'd1);

      // One more operation after the abort to confirm normal service.
      applyStimulus(OP_ADD, 8'h09, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);

      // Drain the scoreboard, with a bound.
      waits = 0;
      while (sbq.size() != 0 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
